ifu_fetch_unit: RTL and testbench

//  Instruction fetch stage sitting directly upstream of the 32-bit decode unit.

---
 rtl/ifu_fetch_unit_pkg.sv | 22 ++
 rtl/ifu_fetch_unit_if.sv | 30 +++
 rtl/ifu_fetch_unit_chk.sv | 26 ++
 rtl/ifu_fetch_unit_fetch_fifo.sv | 70 +++++++
 rtl/ifu_fetch_unit.sv | 137 +++++++++++++
 tb/tb_ifu_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/ifu_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - default instruction / address widths and the reset PC
//   - FSM state encodings (plain localparams so legacy stages can reuse them)
//   - word-alignment helper applied to redirect targets
package ifu_fetch_unit_pkg;

  localparam int unsigned      IFU_INST_MAX = 32;
  localparam int unsigned      IFU_WIDTH    = 32;
  localparam logic [31:0]      IFU_RESET_PC = 32'h8000_0000;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;  // no outstanding request
  localparam logic [1:0] ST_REQ  = 2'd1;  // imem_req asserted at pc
  localparam logic [1:0] ST_WAIT = 2'd2;  // one granted request outstanding
  localparam logic [1:0] ST_DROP = 2'd3;  // outstanding response is stale

  // Force the two low address bits to zero (word aligned fetch target)
  function automatic logic [IFU_WIDTH-1:0] ifu_word_align(input logic [IFU_WIDTH-1:0] addr);
    return {addr[IFU_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_unit_if.sv
// Bus bundle of the fetch unit.
//   imem_*  : req/gnt/rvalid instruction-memory port (fetch unit is requester)
//   inst_*  : valid/ready instruction stream toward decode
// Modports:
//   master : the fetch unit side
//   slave  : memory + decode side (environment)
interface ifu_fetch_unit_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned INST_MAX = 32
);
  logic                imem_req;
  logic [WIDTH-1:0]    imem_addr;
  logic                imem_gnt;
  logic                imem_rvalid;
  logic [INST_MAX-1:0] imem_rdata;
  logic                inst_valid;
  logic                inst_ready;
  logic [INST_MAX-1:0] inst;
  logic [WIDTH-1:0]    inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );
endinterface

// File: rtl/ifu_fetch_unit_chk.sv
// Protocol checker for the fetch unit (simulation only, no outputs).
// Ports: clk, rst_n, fetch state, imem_rvalid, FIFO push/full.
module ifu_fetch_unit_chk
  import ifu_fetch_unit_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] state,
  input logic       imem_rvalid,
  input logic       fifo_push,
  input logic       fifo_full
);

  // A response may only arrive while a request is outstanding
  rvalid_only_when_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> ((state == ST_WAIT) || (state == ST_DROP))
  );

  // The request throttle must keep the FIFO from overflowing
  no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    fifo_push |-> !fifo_full
  );

endmodule

// File: rtl/ifu_fetch_unit_fetch_fifo.sv
// 2-entry synchronous FIFO holding {pc, inst} pairs for decode.
// Ports:
//   push/push_data : write an entry (ignored when full without a pop)
//   pop            : drop head entry (ignored when empty)
//   flush          : empty the FIFO, has priority over push/pop
//   full/empty/count, head_data : registered state
module ifu_fetch_unit_fetch_fifo #(
  parameter int unsigned DW = 64
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count,
  output logic [DW-1:0] head_data
);

  logic [DW-1:0] mem_r [2];
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [1:0]    count_r;
  logic [1:0]    count_nxt_s;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == 2'd2);
  assign empty     = (count_r == 2'd0);
  assign count     = count_r;
  assign head_data = mem_r[rd_ptr_r];

  // Qualify push/pop and compute the next occupancy
  always_comb begin
    do_pop_s  = pop & (count_r != 2'd0);
    do_push_s = push & ((count_r != 2'd2) | do_pop_s);
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= {DW{1'b0}};
      mem_r[1] <= {DW{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: rtl/ifu_fetch_unit.sv
// Instruction fetch stage.
// Owns the PC, issues one in-order word fetch at a time on the imem port,
// buffers up to two {pc, inst} words and hands them to decode.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   redirect_valid  : one-cycle pulse; load redirect_pc (word aligned) and flush
//   redirect_pc     : redirect target
//   bus (master)    : imem req/addr/gnt/rvalid/rdata and inst valid/ready/inst/pc
module ifu_fetch_unit
  import ifu_fetch_unit_pkg::*;
#(
  parameter int unsigned      INST_MAX = IFU_INST_MAX,
  parameter int unsigned      WIDTH    = IFU_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = IFU_RESET_PC
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  ifu_fetch_unit_if.master bus
);

  localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'd4};

  logic [1:0]              state_r;
  logic [1:0]              state_nxt_s;
  logic [WIDTH-1:0]        pc_r;
  logic [WIDTH-1:0]        pc_nxt_s;
  logic [WIDTH-1:0]        req_pc_r;
  logic                    push_s;
  logic                    pop_s;
  logic                    full_s;
  logic                    empty_s;
  logic [1:0]              count_s;
  logic [WIDTH+INST_MAX-1:0] head_s;

  assign bus.imem_req   = (state_r == ST_REQ);
  assign bus.imem_addr  = pc_r;
  assign bus.inst_valid = ~empty_s;
  assign bus.inst_pc    = head_s[WIDTH+INST_MAX-1:INST_MAX];
  assign bus.inst       = head_s[INST_MAX-1:0];

  // A pop in a redirect cycle is moot: the flush wins anyway
  assign pop_s = ~empty_s & bus.inst_ready & ~redirect_valid;

  // Next state / next PC; redirect outranks every other event
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    push_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (redirect_valid) begin
          pc_nxt_s    = ifu_word_align(redirect_pc);
          state_nxt_s = ST_REQ;
        end else if (!full_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          pc_nxt_s = ifu_word_align(redirect_pc);
          // a request granted this very cycle still owes us a response
          state_nxt_s = bus.imem_gnt ? ST_DROP : ST_REQ;
        end else if (bus.imem_gnt) begin
          pc_nxt_s    = pc_r + PC_STEP;
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_nxt_s    = ifu_word_align(redirect_pc);
          state_nxt_s = bus.imem_rvalid ? ST_REQ : ST_DROP;
        end else if (bus.imem_rvalid) begin
          push_s = 1'b1;
          // room for another word once this one lands?
          state_nxt_s = ((count_s == 2'd0) || pop_s) ? ST_REQ : ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (redirect_valid) begin
          pc_nxt_s = ifu_word_align(redirect_pc);
        end else begin
          pc_nxt_s = pc_r;
        end
        state_nxt_s = bus.imem_rvalid ? ST_REQ : ST_DROP;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, fetch PC and PC of the outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      pc_r     <= RESET_PC;
      req_pc_r <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      if ((state_r == ST_REQ) && bus.imem_gnt) begin
        req_pc_r <= pc_r;
      end
    end
  end

  ifu_fetch_unit_fetch_fifo #(.DW(WIDTH + INST_MAX)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data ({req_pc_r, bus.imem_rdata}),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s),
    .head_data (head_s)
  );

  ifu_fetch_unit_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state_r),
    .imem_rvalid (bus.imem_rvalid),
    .fifo_push   (push_s),
    .fifo_full   (full_s)
  );

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Scoreboard bench for ifu_fetch_unit: directed tests push expected fetch
// addresses and delivered {pc, inst} pairs; a monitor pops and compares.
module tb_ifu_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ifu_fetch_unit_if #(.WIDTH(32), .INST_MAX(32)) bus ();

  ifu_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  logic [31:0] exp_addr_q [$];
  exp_t        exp_inst_q [$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  bit          gnt_en;
  int          resp_delay;
  bit          fixed_data;
  int          pend_cnt;
  logic [31:0] pend_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory model: grants when enabled, answers resp_delay cycles after gnt
  initial begin
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    pend_cnt = 0; pend_addr = 32'h0;
    forever begin
      @(negedge clk);
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0;
      if (!rst_n) begin
        pend_cnt = 0;
      end else begin
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata = fixed_data ? 32'h0000_0013 : inst_of(pend_addr);
          end
        end
        if (gnt_en && bus.imem_req) begin
          bus.imem_gnt = 1'b1;
          pend_cnt = resp_delay;
          pend_addr = bus.imem_addr;
        end
      end
    end
  end

  // Monitor: compare granted addresses and delivered words against the queues
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        if (bus.imem_req && bus.imem_gnt && exp_addr_q.size() > 0)
          check("imem_addr", bus.imem_addr, exp_addr_q.pop_front());
        if (bus.inst_valid && bus.inst_ready && exp_inst_q.size() > 0) begin
          exp_t e;
          e = exp_inst_q.pop_front();
          check("inst_pc", bus.inst_pc, e.pc);
          check("inst", bus.inst, e.inst);
        end
      end
    end
  end

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect_valid = 1'b0; bus.inst_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drained(input string name);
    check({name, "_addr_drained"}, 32'(exp_addr_q.size()), 32'd0);
    check({name, "_inst_drained"}, 32'(exp_inst_q.size()), 32'd0);
    exp_addr_q.delete();
    exp_inst_q.delete();
  endtask

  task automatic wait_grant();
    bit found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (bus.imem_req && bus.imem_gnt) begin
        found = 1'b1;
        break;
      end
    end
    check("grant_seen", 32'(found), 32'd1);
  endtask

  task automatic push_inst(input logic [31:0] pc);
    exp_inst_q.push_back('{pc: pc, inst: inst_of(pc)});
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    bus.inst_ready = 1'b0;
    gnt_en = 1'b1; resp_delay = 1; fixed_data = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_imem_addr", bus.imem_addr, 32'h8000_0000);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);

    // 1: streaming fetch, constant data 0x13
    fixed_data = 1'b1; bus.inst_ready = 1'b1;
    exp_addr_q = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    exp_inst_q.push_back('{pc: 32'h8000_0000, inst: 32'h0000_0013});
    exp_inst_q.push_back('{pc: 32'h8000_0004, inst: 32'h0000_0013});
    release_reset();
    @(negedge clk); #3;
    check("first_req_latency", 32'(bus.imem_req), 32'd1);
    run(12);
    drained("t1");

    // 2: decode stalled, FIFO fills to 2 and requests stop
    hold_reset();
    fixed_data = 1'b0; resp_delay = 1;
    exp_addr_q = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
    push_inst(32'h8000_0000); push_inst(32'h8000_0004);
    push_inst(32'h8000_0008); push_inst(32'h8000_000C);
    release_reset();
    run(10);
    #3;
    check("full_inst_valid", 32'(bus.inst_valid), 32'd1);
    check("full_imem_req", 32'(bus.imem_req), 32'd0);
    check("full_inst_pc", bus.inst_pc, 32'h8000_0000);
    @(negedge clk); #3;
    check("full_hold_req", 32'(bus.imem_req), 32'd0);
    check("full_hold_inst", bus.inst, inst_of(32'h8000_0000));
    @(negedge clk);
    bus.inst_ready = 1'b1;
    run(20);
    drained("t2");

    // 3: redirect while WAIT, stale response dropped
    hold_reset();
    resp_delay = 3; bus.inst_ready = 1'b1;
    exp_addr_q = '{32'h8000_0000, 32'h8000_0100, 32'h8000_0104};
    push_inst(32'h8000_0100); push_inst(32'h8000_0104);
    release_reset();
    wait_grant();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    check("t3_drop_no_req", 32'(bus.imem_req), 32'd0);
    run(25);
    drained("t3");

    // 4: redirect in the gnt cycle, second redirect during DROP
    hold_reset();
    resp_delay = 3; bus.inst_ready = 1'b1;
    exp_addr_q = '{32'h8000_0000, 32'h8000_0300, 32'h8000_0304};
    push_inst(32'h8000_0300); push_inst(32'h8000_0304);
    release_reset();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    @(negedge clk);
    redirect_pc = 32'h8000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    check("t4_drop_no_req", 32'(bus.imem_req), 32'd0);
    run(25);
    drained("t4");

    // 5: PC wrap at the top of the address space
    hold_reset();
    resp_delay = 1; bus.inst_ready = 1'b1; gnt_en = 1'b0;
    exp_addr_q = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    push_inst(32'hFFFF_FFFC); push_inst(32'h0000_0000); push_inst(32'h0000_0004);
    release_reset();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0; gnt_en = 1'b1;
    #3;
    check("t5_req_addr", bus.imem_addr, 32'hFFFF_FFFC);
    run(20);
    drained("t5");

    // 7: redirect flushes a full FIFO
    hold_reset();
    resp_delay = 1; bus.inst_ready = 1'b0;
    exp_addr_q = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0040, 32'h8000_0044};
    push_inst(32'h8000_0040); push_inst(32'h8000_0044);
    release_reset();
    run(8);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    check("t7_flush_valid", 32'(bus.inst_valid), 32'd0);
    run(8);
    bus.inst_ready = 1'b1;
    run(12);
    drained("t7");

    // 6: async reset mid-WAIT with a buffered word
    hold_reset();
    resp_delay = 5; bus.inst_ready = 1'b0;
    exp_addr_q = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0000};
    release_reset();
    wait_grant();
    wait_grant();
    @(negedge clk);
    check("t6_valid_before", 32'(bus.inst_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("t6_rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("t6_rst_inst_pc", bus.inst_pc, 32'h0);
    repeat (2) @(negedge clk);
    resp_delay = 1; bus.inst_ready = 1'b1;
    push_inst(32'h8000_0000);
    release_reset();
    run(12);
    drained("t6");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
